// File: rtl/valet_dispatch_arbiter.sv
// valet_dispatch_arbiter
// Round-robin arbiter/sequencer sharing one parking_lot_lifo between NUM_VALETS
// requesters. Each granted operation walks IDLE -> ISSUE -> CAPTURE -> RESP,
// issuing at most one single-cycle lot strobe and returning a tagged response.
// Optional feature: define VALET_RETRIEVE_PRIORITY_EN to give pending retrieves
// precedence over parks (round-robin is then applied inside the retrieve set).
module valet_dispatch_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_VALETS = 4,
    parameter int ID_WIDTH   = $clog2(NUM_VALETS)
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [NUM_VALETS-1:0]            req_valid,
    input  logic [NUM_VALETS-1:0]            req_op,
    input  logic [NUM_VALETS*DATA_WIDTH-1:0] req_data,
    output logic [NUM_VALETS-1:0]            req_ready,
    output logic                             resp_valid,
    output logic [ID_WIDTH-1:0]              resp_id,
    output logic [DATA_WIDTH-1:0]            resp_data,
    output logic                             resp_err,
    output logic                             busy,
    output logic                             lot_write_enable,
    output logic                             lot_read_enable,
    output logic [DATA_WIDTH-1:0]            lot_data_in,
    input  logic [DATA_WIDTH-1:0]            lot_data_out,
    input  logic                             lot_full,
    input  logic                             lot_empty,
    input  logic                             lot_cooldown_active
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    state_t                  state_r;
    logic [ID_WIDTH-1:0]     rr_ptr_r;
    logic [ID_WIDTH-1:0]     win_id_r;
    logic                    win_op_r;
    logic                    err_r;

    logic [NUM_VALETS-1:0]   req_ready_r;
    logic                    resp_valid_r;
    logic [ID_WIDTH-1:0]     resp_id_r;
    logic [DATA_WIDTH-1:0]   resp_data_r;
    logic                    resp_err_r;
    logic                    busy_r;
    logic                    lot_we_r;
    logic                    lot_re_r;
    logic [DATA_WIDTH-1:0]   lot_data_in_r;

    logic [NUM_VALETS-1:0]   cand_s;
    logic                    found_s;
    int                      scan_idx_s;
    logic [ID_WIDTH-1:0]     scan_id_s;
    logic [ID_WIDTH-1:0]     win_id_s;
    logic                    win_op_s;
    logic [DATA_WIDTH-1:0]   win_data_s;
    logic                    err_s;
    logic [ID_WIDTH-1:0]     rr_next_s;
    logic [NUM_VALETS-1:0]   grant_s;

    // Pick the winner: cyclic scan from rr_ptr over the eligible requesters.
    always_comb begin
        cand_s = req_valid;
`ifdef VALET_RETRIEVE_PRIORITY_EN
        if (|(req_valid & req_op)) begin
            cand_s = req_valid & req_op;
        end else begin
            cand_s = req_valid;
        end
`endif
        found_s    = 1'b0;
        win_id_s   = '0;
        scan_idx_s = 0;
        scan_id_s  = '0;
        for (int k = 0; k < NUM_VALETS; k++) begin
            scan_idx_s = int'(rr_ptr_r) + k;
            if (scan_idx_s >= NUM_VALETS) begin
                scan_idx_s = scan_idx_s - NUM_VALETS;
            end else begin
                scan_idx_s = scan_idx_s;
            end
            scan_id_s = ID_WIDTH'(scan_idx_s);
            if (!found_s && cand_s[scan_id_s]) begin
                found_s  = 1'b1;
                win_id_s = scan_id_s;
            end else begin
                found_s  = found_s;
            end
        end
        win_data_s = '0;
        grant_s    = '0;
        for (int k = 0; k < NUM_VALETS; k++) begin
            if (win_id_s == ID_WIDTH'(k)) begin
                win_data_s = req_data[k*DATA_WIDTH +: DATA_WIDTH];
                grant_s[k] = 1'b1;
            end else begin
                grant_s[k] = 1'b0;
            end
        end
        win_op_s = req_op[win_id_s];
        // Park needs room, retrieve needs an entry.
        err_s    = win_op_s ? lot_empty : lot_full;
        if (win_id_s == ID_WIDTH'(NUM_VALETS - 1)) begin
            rr_next_s = '0;
        end else begin
            rr_next_s = win_id_s + ID_WIDTH'(1);
        end
    end

    // Sequencer FSM with registered grant, strobe and response outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            rr_ptr_r      <= '0;
            win_id_r      <= '0;
            win_op_r      <= 1'b0;
            err_r         <= 1'b0;
            req_ready_r   <= '0;
            resp_valid_r  <= 1'b0;
            resp_id_r     <= '0;
            resp_data_r   <= '0;
            resp_err_r    <= 1'b0;
            busy_r        <= 1'b0;
            lot_we_r      <= 1'b0;
            lot_re_r      <= 1'b0;
            lot_data_in_r <= '0;
        end else begin
            // Pulse outputs default low; only the owning state raises them.
            req_ready_r   <= '0;
            resp_valid_r  <= 1'b0;
            resp_id_r     <= '0;
            resp_data_r   <= '0;
            resp_err_r    <= 1'b0;
            lot_we_r      <= 1'b0;
            lot_re_r      <= 1'b0;
            lot_data_in_r <= '0;
            case (state_r)
                ST_IDLE: begin
                    if (!lot_cooldown_active && found_s) begin
                        state_r     <= ST_ISSUE;
                        busy_r      <= 1'b1;
                        rr_ptr_r    <= rr_next_s;
                        win_id_r    <= win_id_s;
                        win_op_r    <= win_op_s;
                        err_r       <= err_s;
                        req_ready_r <= grant_s;
                        // An operation the lot cannot accept never reaches it.
                        if (!err_s) begin
                            lot_we_r      <= ~win_op_s;
                            lot_re_r      <= win_op_s;
                            lot_data_in_r <= win_data_s;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    state_r <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    // Pop data is valid now; register it straight into the response.
                    state_r      <= ST_RESP;
                    resp_valid_r <= 1'b1;
                    resp_id_r    <= win_id_r;
                    resp_err_r   <= err_r;
                    resp_data_r  <= (win_op_r && !err_r) ? lot_data_out : '0;
                end
                ST_RESP: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready        = req_ready_r;
    assign resp_valid       = resp_valid_r;
    assign resp_id          = resp_id_r;
    assign resp_data        = resp_data_r;
    assign resp_err         = resp_err_r;
    assign busy             = busy_r;
    assign lot_write_enable = lot_we_r;
    assign lot_read_enable  = lot_re_r;
    assign lot_data_in      = lot_data_in_r;

endmodule

// File: doc/valet_dispatch_arbiter.md
# valet_dispatch_arbiter

Round-robin arbiter and sequencer that shares one `parking_lot_lifo` instance between `NUM_VALETS` requesters. Each requester asks either to park (push) or to retrieve (pop). The block serialises these operations, drives the lot's single-cycle `write_enable`/`read_enable` strobes and respects the lot's full, empty and cooldown flags. It returns a tagged response to each requester, including an error response for any operation the lot cannot accept.

## Interface
Parameters:
- `DATA_WIDTH`, 16, width of a parked ticket word; must match the lot.
- `NUM_VALETS`, 4, number of requesters; range 2..16.
- `ID_WIDTH`, `$clog2(NUM_VALETS)`, width of the requester index.

Ports:
- `clk`  in  1  sole clock; all logic on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_VALETS  per-requester request; held until that requester's `req_ready` bit pulses.
- `req_op`  in  NUM_VALETS  per-requester operation; 0 = park, 1 = retrieve.
- `req_data`  in  NUM_VALETS*DATA_WIDTH  park words; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_ready`  out  NUM_VALETS  one-hot, one-cycle grant pulse.
- `resp_valid`  out  1  one-cycle response pulse.
- `resp_id`  out  ID_WIDTH  index of the requester being answered.
- `resp_data`  out  DATA_WIDTH  retrieved word; 0 on park or on error.
- `resp_err`  out  1  set when a park was attempted on a full lot or a retrieve on an empty lot.
- `busy`  out  1  high whenever the state is not IDLE.
- `lot_write_enable`  out  1  push strobe to the lot.
- `lot_read_enable`  out  1  pop strobe to the lot.
- `lot_data_in`  out  DATA_WIDTH  push data to the lot.
- `lot_data_out`  in  DATA_WIDTH  pop data from the lot.
- `lot_full`  in  1  lot full flag.
- `lot_empty`  in  1  lot empty flag.
- `lot_cooldown_active`  in  1  lot cooldown flag.

## Operation
- **Reset values.** Every output is 0. The state is IDLE and the round-robin pointer `rr_ptr` is 0.
- **FSM states.** IDLE → ISSUE → CAPTURE → RESP → IDLE. Every state except IDLE lasts exactly one cycle.
- **IDLE.** Arbitration happens only when `lot_cooldown_active` = 0 and at least one `req_valid` bit is set; otherwise the block stays in IDLE.
  - The winner is the first asserted index found by scanning cyclically from `rr_ptr`.
  - The block registers the winner's id, op and data.
  - It registers `err` = (op = park and `lot_full`) or (op = retrieve and `lot_empty`).
  - Next state is ISSUE, and `rr_ptr` becomes (winner + 1) mod NUM_VALETS.
- **ISSUE.**
  - `req_ready[winner]` = 1.
  - If `err` = 0, the block asserts exactly one of `lot_write_enable` or `lot_read_enable`, with `lot_data_in` = the registered data.
  - If `err` = 1, neither strobe is asserted.
- **CAPTURE.** The block registers `lot_data_out` if the op is retrieve and `err` = 0; otherwise it registers 0.
- **RESP.** `resp_valid` = 1, and `resp_id`, `resp_data` and `resp_err` are driven from the registered values. These outputs return to 0 in the following cycle.
- **Strobe guarantees.**
  - The two lot strobes are never high together.
  - Each strobe is high for exactly one cycle.
  - At most one lot operation is in flight at any time.
- **Cooldown handling.** `lot_cooldown_active` is sampled only in IDLE. A new grant therefore waits for the lot's cooldown from the previous operation to clear.
- **Requester changes.**
  - If a requester drops `req_valid` before it is granted, it is simply not considered.
  - Changing `req_op` or `req_data` while waiting for a grant is permitted; the values sampled in IDLE are the ones used.
- **Mid-operation reset.** An async `reset_n` assertion in any state immediately returns the block to IDLE with all outputs 0. The pending response is dropped and no strobe is issued.

## Timing
- The winner is chosen in cycle t, while in IDLE.
- `req_ready` and the lot strobe are high in cycle t+1.
- The lot samples the strobe at the edge that ends t+1; `lot_data_out` is valid in t+2.
- `resp_valid` is high in cycle t+3.
- The earliest next grant decision is at t+4, and only if cooldown is clear.
- Fixed latency from grant to response is 2 cycles. Error responses have the same latency.
- Maximum throughput is one operation per 4 cycles, plus the lot's cooldown.

## Configuration
- **Macro `VALET_RETRIEVE_PRIORITY_EN`.**
  - When defined: if any valid requester has op = retrieve, arbitration in IDLE considers only retrieve requesters. The round-robin scan from `rr_ptr` is applied within that subset. This drains the lot ahead of new arrivals.
  - When undefined: pure round-robin across all valid requesters regardless of op.

## Test plan
- **Reset.** Assert `reset_n` = 0 with `req_valid` = 4'b1111 → all outputs stay 0. After release with the lot empty, the first grant goes to requester 0 (`rr_ptr` = 0).
- **Round-robin fairness.** Four requesters, all parking 0x0A00+i continuously, lot depth 8, cooldown 1 → grant order is 0, 1, 2, 3, 0. Each `resp_valid` arrives exactly 2 cycles after its `req_ready`, with `resp_err` = 0.
- **Retrieve data path.**
  1. Requester 2 parks 0xBEEF.
  2. Requester 1 parks 0x1234.
  3. Requester 3 retrieves → `resp_id` = 3, `resp_data` = 0x1234.
  4. Requester 3 retrieves again → `resp_data` = 0xBEEF.
- **Errors.**
  - Retrieve on an empty lot → `resp_err` = 1, `resp_data` = 0, and neither lot strobe is asserted.
  - Park on a full lot (8 entries) → `resp_err` = 1 and `lot_write_enable` is never asserted.
- **Cooldown gating.** Force `lot_cooldown_active` = 1 for 5 cycles while `req_valid` is high → no `req_ready` during that window. The grant occurs on the first IDLE cycle with cooldown = 0.
- **Mid-operation reset and retrieve priority.**
  - Assert `reset_n` = 0 during ISSUE → the strobe drops immediately and no `resp_valid` follows.
  - With `VALET_RETRIEVE_PRIORITY_EN` defined, requesters 0 and 1 park and requester 3 retrieves simultaneously → requester 3 is granted first.
